// File: rtl/hyperram_responder.sv
// HyperRAM device-side responder: decodes the 48-bit command/address, applies the
// configured initial latency and serves memory or CR0/ID0 register accesses.
module hyperram_responder #(
  parameter int          G_ADDR_BITS = 10,
  parameter logic [15:0] G_ID0       = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        hb_rstn_i,
  input  logic [1:0]  hb_ck_ddr_i,
  input  logic        hb_csn_i,
  input  logic [15:0] hb_dq_ddr_out_i,
  input  logic        hb_dq_oe_i,
  input  logic [1:0]  hb_rwds_ddr_out_i,
  input  logic        hb_rwds_oe_i,
  output logic [15:0] hb_dq_ddr_in_o,
  output logic        hb_dq_ie_o,
  output logic        hb_rwds_in_o
);

  localparam int          DEPTH   = 1 << G_ADDR_BITS;
  localparam logic [15:0] CR0_RST = 16'h8F1F;

  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LAT, S_WRITE, S_REGWR, S_READ, S_IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  hdr_q, hdr_d;          // {read, register space}
  logic [28:0] ahi_q, ahi_d;          // CA[44:16]
  logic        ca_cnt_q, ca_cnt_d;    // 1 once CA[31:16] is held
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        is_reg_q, is_reg_d;
  logic [15:0] cr0_q, cr0_d;
  logic [15:0] dq_q, dq_d;
  logic        ie_q, ie_d;

  logic [15:0]            mem [DEPTH];
  logic                   mem_we;
  logic [1:0]             mem_be;
  logic [G_ADDR_BITS-1:0] mem_idx;
  logic                   active;
  logic [31:0]            ca_addr;
  logic [31:0]            addr_inc;
  logic [15:0]            rdata;
  logic                   unused_inputs;

  assign unused_inputs = hb_rwds_oe_i;

  function automatic logic [3:0] latency_of(input logic [15:0] cr0);
    logic [3:0] lat;
    case (cr0[7:4])
      4'h0:    lat = 4'd5;
      4'h1:    lat = 4'd6;
      4'hE:    lat = 4'd3;
      4'hF:    lat = 4'd4;
      default: lat = 4'd6;
    endcase
    return cr0[3] ? {lat[2:0], 1'b0} : lat;
  endfunction

  assign active   = !hb_csn_i && (hb_ck_ddr_i != 2'b00);
  assign ca_addr  = {ahi_q, hb_dq_ddr_out_i[2:0]};
  assign mem_idx  = addr_q[G_ADDR_BITS-1:0];
  // Register space counts freely; memory space wraps at the array depth.
  assign addr_inc = is_reg_q ? addr_q + 32'd1 : 32'(mem_idx + G_ADDR_BITS'(1));

  always_comb begin
    rdata = mem[mem_idx];
    if (is_reg_q) begin
      if (addr_q == 32'h0)        rdata = G_ID0;
      else if (addr_q == 32'h800) rdata = cr0_q;
      else                        rdata = 16'h0;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    ahi_d     = ahi_q;
    ca_cnt_d  = ca_cnt_q;
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    is_reg_d  = is_reg_q;
    cr0_d     = cr0_q;
    dq_d      = dq_q;
    ie_d      = 1'b0;
    mem_we    = 1'b0;
    mem_be    = ~hb_rwds_ddr_out_i;

    if (!hb_rstn_i) begin
      state_d = S_IDLE;
      cr0_d   = CR0_RST;
    end else if (hb_csn_i) begin
      state_d = S_IDLE;
    end else if (active) begin
      case (state_q)
        S_IDLE: begin
          hdr_d         = hb_dq_ddr_out_i[15:14];
          ahi_d[28:16]  = hb_dq_ddr_out_i[12:0];
          ca_cnt_d      = 1'b0;
          state_d       = S_CA;
        end
        S_CA: begin
          if (!ca_cnt_q) begin
            ahi_d[15:0] = hb_dq_ddr_out_i;
            ca_cnt_d    = 1'b1;
          end else begin
            is_reg_d = hdr_q[0];
            addr_d   = hdr_q[0] ? ca_addr : 32'(ca_addr[G_ADDR_BITS-1:0]);
            if (hdr_q == 2'b01) begin
              state_d = S_REGWR;
            end else begin
              state_d   = S_LAT;
              lat_cnt_d = latency_of(cr0_q);
            end
          end
        end
        S_LAT: begin
          lat_cnt_d = lat_cnt_q - 4'd1;
          if (lat_cnt_q == 4'd1) state_d = hdr_q[1] ? S_READ : S_WRITE;
        end
        S_WRITE: begin
          if (hb_dq_oe_i) begin
            mem_we = 1'b1;
            addr_d = addr_inc;
          end
        end
        S_REGWR: begin
          cr0_d   = hb_dq_ddr_out_i;
          state_d = S_IGNORE;
        end
        S_READ: begin
          dq_d   = rdata;
          ie_d   = 1'b1;
          addr_d = addr_inc;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      hdr_q     <= '0;
      ahi_q     <= '0;
      ca_cnt_q  <= 1'b0;
      lat_cnt_q <= '0;
      addr_q    <= '0;
      is_reg_q  <= 1'b0;
      cr0_q     <= CR0_RST;
      dq_q      <= '0;
      ie_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      ahi_q     <= ahi_d;
      ca_cnt_q  <= ca_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      is_reg_q  <= is_reg_d;
      cr0_q     <= cr0_d;
      dq_q      <= dq_d;
      ie_q      <= ie_d;
    end
  end

  // NOTE: the memory array has no reset; its contents must survive both resets.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      if (mem_be[1]) mem[mem_idx][15:8] <= hb_dq_ddr_out_i[15:8];
      if (mem_be[0]) mem[mem_idx][7:0]  <= hb_dq_ddr_out_i[7:0];
    end
  end

  assign hb_dq_ddr_in_o = dq_q;
  assign hb_dq_ie_o     = ie_q;
  assign hb_rwds_in_o   = cr0_q[3] && (state_q == S_CA || state_q == S_LAT);

endmodule

// File: tb/tb_hyperram_responder.sv
// Scoreboard bench for hyperram_responder: a behavioural model predicts read data,
// a monitor pops expectations whenever the responder flags valid read data.
module tb_hyperram_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rstn, hb_rstn, hb_csn, hb_dq_oe, hb_rwds_oe;
  logic [1:0]  hb_ck, hb_rwds;
  logic [15:0] hb_dq_out;
  logic [15:0] dq_in;
  logic        dq_ie, rwds_in;

  always #5 clk = ~clk;

  hyperram_responder #(.G_ADDR_BITS(10), .G_ID0(16'h0C81)) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .hb_rstn_i         (hb_rstn),
    .hb_ck_ddr_i       (hb_ck),
    .hb_csn_i          (hb_csn),
    .hb_dq_ddr_out_i   (hb_dq_out),
    .hb_dq_oe_i        (hb_dq_oe),
    .hb_rwds_ddr_out_i (hb_rwds),
    .hb_rwds_oe_i      (hb_rwds_oe),
    .hb_dq_ddr_in_o    (dq_in),
    .hb_dq_ie_o        (dq_ie),
    .hb_rwds_in_o      (rwds_in)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_cr0;
  logic [15:0] wd[$];
  logic [1:0]  wm[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: initial latency in active cycles from the CR0 latency code and fixed bit.
  function automatic int m_latency();
    int lat;
    case (m_cr0[7:4])
      4'd0:    lat = 5;
      4'd1:    lat = 6;
      4'd14:   lat = 3;
      4'd15:   lat = 4;
      default: lat = 6;
    endcase
    return m_cr0[3] ? 2 * lat : lat;
  endfunction

  function automatic logic [15:0] m_read(input logic rs, input logic [31:0] a);
    if (rs) begin
      if (a == 32'h0)   return 16'h0C81;
      if (a == 32'h800) return m_cr0;
      return 16'h0;
    end
    return m_mem[a % DEPTH];
  endfunction

  function automatic logic [47:0] make_ca(input logic rw, input logic rs, input logic [31:0] addr);
    logic [47:0] ca;
    ca        = '0;
    ca[47]    = rw;
    ca[46]    = rs;
    ca[45]    = 1'($urandom);
    ca[44:16] = addr[31:3];
    ca[15:3]  = 13'($urandom);
    ca[2:0]   = addr[2:0];
    return ca;
  endfunction

  task automatic cyc(input logic csn, input logic [1:0] ck, input logic [15:0] dq,
                     input logic oe, input logic [1:0] msk);
    @(negedge clk);
    hb_csn    = csn;
    hb_ck     = ck;
    hb_dq_out = dq;
    hb_dq_oe  = oe;
    hb_rwds   = msk;
  endtask

  // One active word, sometimes preceded by an inactive (clock-stopped) cycle with junk on DQ.
  task automatic word(input logic [15:0] dq, input logic oe, input logic [1:0] msk);
    if ($urandom_range(3) == 0) cyc(1'b0, 2'b00, 16'($urandom), 1'b1, 2'b00);
    cyc(1'b0, 2'($urandom_range(3, 1)), dq, oe, msk);
  endtask

  task automatic end_access();
    cyc(1'b1, 2'b00, 16'h0, 1'b0, 2'b00);
    cyc(1'b1, 2'b00, 16'h0, 1'b0, 2'b00);
  endtask

  task automatic send_ca(input logic [47:0] ca, input int nwords);
    word(ca[47:32], 1'b1, 2'b00);
    @(posedge clk); #1;
    check("rwds_in_ca", rwds_in, m_cr0[3]);
    if (nwords > 1) word(ca[31:16], 1'b1, 2'b00);
    if (nwords > 2) word(ca[15:0], 1'b1, 2'b00);
  endtask

  task automatic latency_phase();
    int l;
    l = m_latency();
    for (int i = 0; i < l; i++) begin
      word(16'($urandom), 1'b0, 2'($urandom));
      if (i == 0) begin
        @(posedge clk); #1;
        check("rwds_in_lat", rwds_in, m_cr0[3]);
      end
    end
  endtask

  task automatic mem_write(input logic [31:0] addr);
    int idx;
    send_ca(make_ca(1'b0, 1'b0, addr), 3);
    latency_phase();
    for (int i = 0; i < wd.size(); i++) begin
      word(wd[i], 1'b1, wm[i]);
      idx = int'((addr + 32'(i)) % DEPTH);
      if (!wm[i][1]) m_mem[idx][15:8] = wd[i][15:8];
      if (!wm[i][0]) m_mem[idx][7:0]  = wd[i][7:0];
    end
    end_access();
  endtask

  task automatic read(input logic rs, input logic [31:0] addr, input int n);
    send_ca(make_ca(1'b1, rs, addr), 3);
    latency_phase();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_read(rs, addr + 32'(i)));
      word(16'($urandom), 1'b0, 2'($urandom));
    end
    end_access();
  endtask

  task automatic reg_write(input logic [47:0] ca, input logic [15:0] data);
    send_ca(ca, 3);
    word(data, 1'b1, 2'b00);
    m_cr0 = data;
    word(16'($urandom), 1'b1, 2'b00);
    word(16'($urandom), 1'b1, 2'b00);
    end_access();
  endtask

  // Monitor: every valid read word must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rstn && dq_ie) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read: got %0h expected no read data", dq_in);
        end else begin
          check("read_data", dq_in, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; hb_rstn = 1'b1; hb_csn = 1'b1; hb_ck = 2'b00;
    hb_dq_out = '0; hb_dq_oe = 1'b0; hb_rwds = 2'b00; hb_rwds_oe = 1'b0;
    m_cr0 = 16'h8F1F;
    #23;
    check("reset_dq", dq_in, 16'h0);
    check("reset_ie", dq_ie, 1'b0);
    check("reset_rwds", rwds_in, 1'b0);
    @(negedge clk) rstn = 1'b1;

    // Default register contents and register-space burst.
    read(1'b1, 32'h0, 1);
    read(1'b1, 32'h800, 1);
    read(1'b1, 32'h7FF, 2);

    // CR0 write: latency 3, fixed.
    reg_write(48'h6000_0100_0000, 16'h8FEC);
    read(1'b1, 32'h800, 1);

    // Fill the whole array with a burst that wraps through address 0.
    wd.delete(); wm.delete();
    for (int i = 0; i < DEPTH; i++) begin
      wd.push_back(16'($urandom));
      wm.push_back(2'b00);
    end
    mem_write(32'h200);

    wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444}; wm = '{2'b00, 2'b00, 2'b00, 2'b00};
    mem_write(32'd5);
    read(1'b0, 32'd5, 4);

    wd = '{16'hABCD}; wm = '{2'b10};
    mem_write(32'd8);
    read(1'b0, 32'd8, 1);

    read(1'b0, 32'd1023, 2);

    // Aborted CA after two words, then a fresh access.
    send_ca(make_ca(1'b1, 1'b0, 32'd7), 2);
    end_access();
    read(1'b0, 32'd7, 2);

    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(4))
        0: begin
          wd.delete(); wm.delete();
          for (int i = 0; i < int'($urandom_range(6, 1)); i++) begin
            wd.push_back(16'($urandom));
            wm.push_back(2'($urandom));
          end
          mem_write($urandom);
        end
        1: read(1'b0, $urandom, int'($urandom_range(6, 1)));
        2: begin
          case ($urandom_range(3))
            0:       read(1'b1, 32'h0, 2);
            1:       read(1'b1, 32'h800, 1);
            2:       read(1'b1, 32'h7FF, 2);
            default: read(1'b1, $urandom, 1);
          endcase
        end
        3: reg_write(make_ca(1'b0, 1'b1, $urandom), 16'($urandom));
        default: begin
          send_ca(make_ca(1'($urandom), 1'($urandom), $urandom), int'($urandom_range(2, 1)));
          end_access();
        end
      endcase
    end

    // Device reset: CR0 returns to default, memory is kept.
    @(negedge clk) hb_rstn = 1'b0;
    @(negedge clk) hb_rstn = 1'b1;
    m_cr0 = 16'h8F1F;
    read(1'b1, 32'h800, 1);
    read(1'b0, 32'd5, 4);

    // Controller reset in the middle of a read burst.
    send_ca(make_ca(1'b1, 1'b0, 32'd100), 3);
    latency_phase();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(m_read(1'b0, 32'd100 + 32'(i)));
      word(16'($urandom), 1'b0, 2'b00);
    end
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check("midread_rst_dq", dq_in, 16'h0);
    check("midread_rst_ie", dq_ie, 1'b0);
    check("midread_rst_rwds", rwds_in, 1'b0);
    check("midread_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    m_cr0 = 16'h8F1F;
    cyc(1'b0, 2'b00, 16'h0, 1'b0, 2'b00);
    @(negedge clk) rstn = 1'b1;
    // Chip select stays low: the first active word must be taken as CA word 0.
    read(1'b1, 32'h0, 1);
    read(1'b1, 32'h800, 1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hyperram_responder.md
HYPERRAM_RESPONDER -- requirements
Module: hyperram_responder

Interface
REQ-001 SHALL have parameter G_ADDR_BITS, default 10, meaning log2 of the internal memory depth in 16-bit words.
REQ-002 SHALL have parameter G_ID0, default 16'h0C81, meaning the value returned for an ID0 register read.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock. All logic is clocked on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port hb_rstn_i, input, 1 bit: device reset from the controller, active low.
REQ-006 SHALL have port hb_ck_ddr_i, input, 2 bits: DDR clock pair.
REQ-007 SHALL have port hb_csn_i, input, 1 bit: chip select, active low.
REQ-008 SHALL have port hb_dq_ddr_out_i, input, 16 bits: controller DQ data; [15:8] is the first-edge byte.
REQ-009 SHALL have port hb_dq_oe_i, input, 1 bit: controller drives DQ.
REQ-010 SHALL have port hb_rwds_ddr_out_i, input, 2 bits: write byte mask; [1] masks [15:8], [0] masks [7:0].
REQ-011 SHALL have port hb_rwds_oe_i, input, 1 bit: controller drives RWDS.
REQ-012 SHALL have port hb_dq_ddr_in_o, output, 16 bits: read data to the controller.
REQ-013 SHALL have port hb_dq_ie_o, output, 1 bit: hb_dq_ddr_in_o is valid.
REQ-014 SHALL have port hb_rwds_in_o, output, 1 bit: latency indicator, 1 = double latency.

Function
REQ-015 Active cycle: hb_csn_i=0 and hb_ck_ddr_i!=2'b00. Each active cycle carries one 16-bit word.
REQ-016 States and transitions:
- IDLE -> CA on the first active cycle.
- CA collects 3 words as CA[47:32], CA[31:16], CA[15:0].
- CA -> LATENCY, WRITE, REGWR or READ, as set by REQ-018 to REQ-020.
REQ-017 Decode:
- R/W# = CA[47] (1 = read).
- Register space = CA[46].
- Word address = {CA[44:16], CA[2:0]}, truncated to G_ADDR_BITS.
- CA[45] is ignored; all bursts are linear.
REQ-018 Register write (CA[47]=0, CA[46]=1), zero latency:
- Go to REGWR.
- The next active word is written to CR0.
- Then go to IGNORE until hb_csn_i=1.
REQ-019 All other accesses: wait L active cycles in LATENCY.
- L = 2*lat when CR0[3]=1 (fixed), else L = lat.
- lat comes from CR0[7:4]: 0000=5, 0001=6, 1110=3, 1111=4, any other value=6.
REQ-020 hb_rwds_in_o SHALL be 1 during CA and LATENCY exactly when CR0[3]=1; otherwise it is 0.
REQ-021 WRITE (memory write), on each active cycle with hb_dq_oe_i=1:
- Write each byte of mem[addr] whose hb_rwds_ddr_out_i bit is 0.
- Then addr+1, wrapping to 0 at 2^G_ADDR_BITS.
REQ-022 READ, for each active cycle:
- On the next clk_i edge: hb_dq_ddr_in_o = data at addr, hb_dq_ie_o = 1 for that single cycle; then addr+1, with the same wrap as REQ-021.
- Memory data comes from mem[addr].
- Register read data: word address 0 returns G_ID0, 0x800 returns CR0, any other address returns 0.
REQ-023 hb_csn_i=1 in any state SHALL return the FSM to IDLE on the next edge and abort any partial CA.
- Memory writes already completed are kept.
REQ-024 Inactive cycles with hb_csn_i=0 SHALL hold state and address; hb_dq_ie_o=0 on those cycles.
REQ-025 hb_rstn_i=0 SHALL:
- force IDLE;
- set CR0 to 16'h8F1F;
- leave memory contents unchanged.

Reset
REQ-026 While rstn_i=0:
- FSM=IDLE, CR0=16'h8F1F, address=0;
- hb_dq_ddr_in_o=0, hb_dq_ie_o=0, hb_rwds_in_o=0.
- Memory contents are not reset.
REQ-027 On release of rstn_i, the first active cycle SHALL be treated as CA word 0.

Verification
REQ-028 Register write CA {0x6000,0x0100,0x0000}, data 16'h8FEC -> CR0=8FEC (latency 3, fixed); hb_rwds_in_o=1 during the CA of the next access.
REQ-029 With CR0=8FEC, memory write to word 5 of 4 words (0x1111..0x4444) after 6 latency cycles, then a read of word 5 burst 4 -> hb_dq_ddr_in_o = 1111, 2222, 3333, 4444 with hb_dq_ie_o=1 on 4 cycles.
REQ-030 Masked write of 0xABCD with rwds 2'b10 over 0x4444 -> read returns 0x44CD.
REQ-031 Read starting at word 1023, burst 2 -> data from mem[1023] then mem[0].
REQ-032 hb_csn_i raised after 2 CA words, then a new access -> the new CA decodes correctly; no data is driven for the aborted access.
REQ-033 Register reads of word 0 and word 0x800 after rstn_i pulse -> 0x0C81 and 0x8F1F; rstn_i asserted mid-READ -> all outputs 0 immediately.
